stack_queue_alu: RTL and testbench

// Parametrised stack/queue arithmetic engine; successor to the fixed 32-entry stack-add datapath behind Top_level.

---
 rtl/sqa_pkg.sv | 19 +
 rtl/stack_queue_alu_if.sv | 22 ++
 rtl/sqa_mem.sv | 18 +
 rtl/stack_queue_alu.sv | 159 +++++++++++++++
 tb/tb_stack_queue_alu.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sqa_pkg.sv
// Shared command indices, FSM/op encodings and the width helper for the
// stack/queue arithmetic engine.
package sqa_pkg;
  localparam int CMD_PUSH = 0;
  localparam int CMD_ADD  = 1;
  localparam int CMD_SUB  = 2;
  localparam int CMD_POP  = 3;
  localparam int CMD_CLR  = 4;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WR} state_t;
  typedef enum logic [1:0] {OP_PUSH, OP_ADD, OP_SUB, OP_POP} op_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/stack_queue_alu_if.sv
// Panel-side bundle: switches/buttons/mode in, display word and status out.
interface stack_queue_alu_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int DISP_W = 32
);
  logic                              stackQueue;
  logic [DATA_W-1:0]                 switches;
  logic [4:0]                        btns;
  logic [DISP_W-1:0]                 toSSEG;
  logic                              empty;
  logic                              full;
  logic [sqa_pkg::clog2(DEPTH):0]    count;
  logic                              busy;
  logic                              error;
  logic                              carry;

  modport slave  (input stackQueue, switches, btns,
                  output toSSEG, empty, full, count, busy, error, carry);
  modport master (output stackQueue, switches, btns,
                  input toSSEG, empty, full, count, busy, error, carry);
endinterface

// File: rtl/sqa_mem.sv
// DEPTH x DATA_W single-port RAM; a write cycle does not update rdata.
module sqa_mem import sqa_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end
endmodule

// File: rtl/stack_queue_alu.sv
// Button-driven LIFO/FIFO word store with add/sub over the two head entries;
// results feed the seven-segment driver.
module stack_queue_alu import sqa_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int DISP_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  stack_queue_alu_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW-1:0] P_TWO = AW'(2);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_TWO = CW'(2);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  state_t            state, state_nx;
  op_t               op;
  logic              mode, err, cry, busy, is_empty, is_full, mem_we;
  logic              sel_push, sel_arith, sel_pop, sel_clr, accept, reject;
  logic [4:0]        btns_q, edges;
  logic [CW-1:0]     cnt, cnt_m1, cnt_m2;
  logic [AW-1:0]     head, tail, a_addr, b_addr, push_addr, res_addr, mem_addr;
  logic [DATA_W-1:0] push_val, opnd_a, opnd_b, res, rdata, mem_wdata;
  logic [DATA_W:0]   alu;
  logic [DISP_W-1:0] disp, ext_sw, ext_rd, ext_res;

  sqa_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(rdata)
  );

  assign edges    = bus.btns & ~btns_q;
  assign busy     = (state != IDLE);
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == C_FULL);
  assign cnt_m1   = cnt - C_ONE;
  assign cnt_m2   = cnt - C_TWO;
  // Stack addresses follow count; queue addresses follow head/tail.
  assign a_addr    = mode ? head         : cnt_m1[AW-1:0];
  assign b_addr    = mode ? head + P_ONE : cnt_m2[AW-1:0];
  assign push_addr = mode ? tail         : cnt[AW-1:0];
  assign res_addr  = mode ? tail         : cnt_m2[AW-1:0];

  always_comb begin
    sel_push  = edges[CMD_PUSH];
    sel_arith = !sel_push && (edges[CMD_ADD] || edges[CMD_SUB]);
    sel_pop   = !sel_push && !edges[CMD_ADD] && !edges[CMD_SUB] && edges[CMD_POP];
    sel_clr   = edges[CMD_CLR] && (busy || edges[3:0] == '0);
    accept    = !busy && ((sel_push && !is_full) || (sel_arith && cnt >= C_TWO) ||
                          (sel_pop && !is_empty));
    reject    = !busy && ((sel_push && is_full) || (sel_arith && cnt < C_TWO) ||
                          (sel_pop && is_empty));
    alu = (op == OP_ADD) ? ({1'b0, opnd_a} + {1'b0, opnd_b})
                         : ({1'b0, opnd_b} - {1'b0, opnd_a});
    ext_sw  = '0; ext_sw[DATA_W-1:0]  = bus.switches;
    ext_rd  = '0; ext_rd[DATA_W-1:0]  = rdata;
    ext_res = '0; ext_res[DATA_W-1:0] = res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_addr  = a_addr;
    mem_wdata = res;
    unique case (state)
      IDLE: if (accept) state_nx = sel_push ? WR : RD_A;
      RD_A: begin
        mem_addr = b_addr;
        state_nx = (op == OP_POP) ? IDLE : RD_B;
      end
      RD_B: state_nx = EXEC;
      EXEC: state_nx = WR;
      WR: begin
        mem_we   = 1'b1;
        state_nx = IDLE;
        if (op == OP_PUSH) begin
          mem_addr  = push_addr;
          mem_wdata = push_val;
        end else begin
          mem_addr = res_addr;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (sel_clr) begin
      state_nx = IDLE;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btns_q <= '0; cnt <= '0; head <= '0; tail <= '0; mode <= 1'b0;
      op <= OP_PUSH; push_val <= '0; opnd_a <= '0; opnd_b <= '0; res <= '0;
      disp <= '0; err <= 1'b0; cry <= 1'b0;
    end else begin
      btns_q <= bus.btns;
      if (sel_clr) begin
        cnt <= '0; head <= '0; tail <= '0; disp <= '0; err <= 1'b0; cry <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cnt == '0) mode <= bus.stackQueue;
            if (reject) err <= 1'b1;
            if (accept) begin
              err <= 1'b0;
              op  <= sel_push ? OP_PUSH : sel_pop ? OP_POP :
                     edges[CMD_ADD] ? OP_ADD : OP_SUB;
              if (sel_push) begin
                push_val <= bus.switches;
                disp     <= ext_sw;
              end
            end
          end
          RD_A: begin
            opnd_a <= rdata;
            if (op == OP_POP) begin
              disp <= ext_rd;
              cnt  <= cnt_m1;
              if (mode) head <= head + P_ONE;
            end
          end
          RD_B: opnd_b <= rdata;
          EXEC: begin
            res <= alu[DATA_W-1:0];
            cry <= alu[DATA_W];
          end
          WR: begin
            // A queue op frees both operand slots before writing at tail.
            if (mode) tail <= tail + P_ONE;
            if (op == OP_PUSH) cnt <= cnt + C_ONE;
            else begin
              cnt  <= cnt_m1;
              disp <= ext_res;
              if (mode) head <= head + P_TWO;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.toSSEG = disp;
  assign bus.empty  = is_empty;
  assign bus.full   = is_full;
  assign bus.count  = cnt;
  assign bus.busy   = busy;
  assign bus.error  = err;
  assign bus.carry  = cry;
endmodule

// File: tb/tb_stack_queue_alu.sv
// Bench for stack_queue_alu: directed table, spec sequences and random
// commands against a queue-based reference model.
module tb_stack_queue_alu;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int DISP_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_queue_alu_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DISP_W(DISP_W)) bus ();
  stack_queue_alu #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DISP_W(DISP_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mq[$];
  logic              m_mode = 1'b0;
  logic [31:0]       m_disp = '0;
  logic              m_err = 1'b0;
  logic              m_cry = 1'b0;

  typedef struct {
    int          cmd;
    logic [15:0] sw;
    logic [31:0] disp;
    int          cnt;
    logic        err;
    logic        cry;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_disp = '0; m_err = 1'b0; m_cry = 1'b0;
  endtask

  // Behavioural reference: back of mq is the stack top / queue tail.
  task automatic model(input int cmd, input logic [15:0] sw, input logic sq);
    logic [15:0] a, b, r;
    int unsigned sum;
    if (mq.size() == 0) m_mode = sq;
    case (cmd)
      0: if (mq.size() == DEPTH) m_err = 1'b1;
         else begin m_err = 1'b0; mq.push_back(sw); m_disp = {16'h0, sw}; end
      1, 2: if (mq.size() < 2) m_err = 1'b1;
         else begin
           if (m_mode) begin a = mq.pop_front(); b = mq.pop_front(); end
           else begin a = mq.pop_back(); b = mq.pop_back(); end
           if (cmd == 1) begin
             sum = int'(a) + int'(b);
             r = sum[15:0]; m_cry = (sum > 32'h0000_FFFF);
           end else begin
             r = b - a; m_cry = (a > b);
           end
           mq.push_back(r); m_disp = {16'h0, r}; m_err = 1'b0;
         end
      3: if (mq.size() == 0) m_err = 1'b1;
         else begin
           m_err = 1'b0;
           if (m_mode) r = mq.pop_front(); else r = mq.pop_back();
           m_disp = {16'h0, r};
         end
      default: model_reset();
    endcase
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 20) begin @(negedge clk); n++; end
    check({name, ".busy_timeout"}, {31'h0, bus.busy}, 32'h0);
  endtask

  task automatic press(input logic [4:0] b, input string name);
    @(negedge clk) bus.btns = b;
    @(negedge clk) bus.btns = '0;
    wait_idle(name);
  endtask

  task automatic cmp_all(input string tag);
    check({tag, ".disp"},  bus.toSSEG, m_disp);
    check({tag, ".count"}, {26'h0, bus.count}, mq.size());
    check({tag, ".error"}, {31'h0, bus.error}, {31'h0, m_err});
    check({tag, ".carry"}, {31'h0, bus.carry}, {31'h0, m_cry});
    check({tag, ".empty"}, {31'h0, bus.empty}, {31'h0, mq.size() == 0});
    check({tag, ".full"},  {31'h0, bus.full},  {31'h0, mq.size() == DEPTH});
  endtask

  task automatic do_cmd(input int cmd, input logic [15:0] sw, input logic sq, input string tag);
    logic [4:0] b;
    bus.switches = sw; bus.stackQueue = sq;
    model(cmd, sw, sq);
    b = '0; b[cmd] = 1'b1;
    press(b, tag);
    cmp_all(tag);
  endtask

  initial begin
    tbl[0]  = '{0, 16'h0005, 32'h0005, 1, 1'b0, 1'b0};
    tbl[1]  = '{0, 16'h0003, 32'h0003, 2, 1'b0, 1'b0};
    tbl[2]  = '{2, 16'h0000, 32'hFFFE, 1, 1'b0, 1'b1};
    tbl[3]  = '{0, 16'h0007, 32'h0007, 2, 1'b0, 1'b1};
    tbl[4]  = '{1, 16'h0000, 32'h0005, 1, 1'b0, 1'b1};
    tbl[5]  = '{3, 16'h0000, 32'h0005, 0, 1'b0, 1'b1};
    tbl[6]  = '{3, 16'h0000, 32'h0005, 0, 1'b1, 1'b1};
    tbl[7]  = '{1, 16'h0000, 32'h0005, 0, 1'b1, 1'b1};
    tbl[8]  = '{0, 16'h0009, 32'h0009, 1, 1'b0, 1'b1};
    tbl[9]  = '{2, 16'h0000, 32'h0009, 1, 1'b1, 1'b1};
    tbl[10] = '{4, 16'h0000, 32'h0000, 0, 1'b0, 1'b0};
    tbl[11] = '{0, 16'h0011, 32'h0011, 1, 1'b0, 1'b0};
    tbl[12] = '{0, 16'h0022, 32'h0022, 2, 1'b0, 1'b0};
    tbl[13] = '{3, 16'h0000, 32'h0011, 1, 1'b0, 1'b0};
    tbl[14] = '{4, 16'h0000, 32'h0000, 0, 1'b0, 1'b0};

    bus.btns = '0; bus.switches = '0; bus.stackQueue = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp_all("reset");
    check("reset.busy", {31'h0, bus.busy}, 32'h0);
    rst = 1'b1;

    // Queue-mode directed table (mode latched while empty)
    for (int i = 0; i < 15; i++) begin
      logic [4:0] b;
      bus.switches = tbl[i].sw; bus.stackQueue = 1'b1;
      b = '0; b[tbl[i].cmd] = 1'b1;
      press(b, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.disp", i), bus.toSSEG, tbl[i].disp);
      check($sformatf("tbl%0d.count", i), {26'h0, bus.count}, tbl[i].cnt);
      check($sformatf("tbl%0d.error", i), {31'h0, bus.error}, {31'h0, tbl[i].err});
      check($sformatf("tbl%0d.carry", i), {31'h0, bus.carry}, {31'h0, tbl[i].cry});
    end

    // Stack fill to full, overflow, then fold with adds
    for (int i = 1; i <= DEPTH; i++) begin
      do_cmd(0, 16'(i), 1'b0, $sformatf("fill%0d", i));
      check($sformatf("fill%0d.sseg", i), bus.toSSEG, i);
    end
    check("full.flag", {31'h0, bus.full}, 32'h1);
    check("full.count", {26'h0, bus.count}, 32);
    do_cmd(0, 16'h0055, 1'b0, "ovf");
    check("ovf.error", {31'h0, bus.error}, 32'h1);
    check("ovf.count", {26'h0, bus.count}, 32);
    check("ovf.sseg", bus.toSSEG, 32'h20);
    for (int k = 1; k < DEPTH; k++) do_cmd(1, 16'h0, 1'b0, $sformatf("fold%0d", k));
    check("fold.sseg", bus.toSSEG, 32'h210);
    check("fold.count", {26'h0, bus.count}, 1);

    // Held button yields one add; simultaneous edges pick push
    do_cmd(4, 16'h0, 1'b0, "clr_a");
    for (int i = 0; i < 4; i++) do_cmd(0, 16'($urandom), 1'b0, $sformatf("hpush%0d", i));
    model(1, 16'h0, 1'b0);
    @(negedge clk) bus.btns = 5'b00010;
    repeat (10) @(negedge clk);
    bus.btns = '0;
    wait_idle("hold");
    cmp_all("hold");
    check("hold.count", {26'h0, bus.count}, 3);
    bus.switches = 16'h1234;
    model(0, 16'h1234, 1'b0);
    press(5'b00011, "dual");
    cmp_all("dual");
    check("dual.count", {26'h0, bus.count}, 4);

    // Random commands against the reference model
    for (int i = 0; i < 300; i++) begin
      int r, cmd;
      r = $urandom_range(0, 99);
      cmd = (r < 40) ? 0 : (r < 55) ? 1 : (r < 70) ? 2 : (r < 92) ? 3 : 4;
      do_cmd(cmd, 16'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset during RD_B of an add
    do_cmd(4, 16'h0, 1'b0, "clr_b");
    do_cmd(0, 16'h00AA, 1'b0, "mid_p0");
    do_cmd(0, 16'h00BB, 1'b0, "mid_p1");
    @(negedge clk) bus.btns = 5'b00010;
    @(posedge clk);
    @(negedge clk) bus.btns = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    cmp_all("midrst");
    check("midrst.busy", {31'h0, bus.busy}, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    cmp_all("post_rst");

    // Clear after three pushes
    for (int i = 0; i < 3; i++) do_cmd(0, 16'(i + 100), 1'b0, $sformatf("cpush%0d", i));
    do_cmd(4, 16'h0, 1'b0, "clear");
    check("clear.count", {26'h0, bus.count}, 0);
    check("clear.sseg", bus.toSSEG, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
